seg_scan_mux: RTL and testbench
===============================

# seg_scan_mux

Time-multiplexed display scanner: the parametrised successor to the static 8:1 digit mux. It cycles through `NUM_DIGITS` digit values of `DIGIT_W` bits at a programmable slot rate. For each slot it drives the selected digit value and an active-low one-hot anode enable. It sits between the digit-producing datapath and the segment decoder / display pins, and replaces the external counter-plus-mux arrangement.

## Interface
- `NUM_DIGITS`, default 8: number of digits scanned. Must be ≥ 2; non-power-of-two is allowed.
- `DIGIT_W`, default 4: bits per digit value.
- `DIV`, default 100000: clock cycles per digit slot. Must be ≥ 2.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `num` input `[NUM_DIGITS-1:0][DIGIT_W-1:0]`: digit values; `num[i]` shows on digit `i`.
- `digit_en` input `NUM_DIGITS`: per-digit enable. 0 blanks that digit.
- `sel` output `$clog2(NUM_DIGITS)`: current slot index (registered).
- `selected_num` output `DIGIT_W`: value for the active digit (registered).
- `anode` output `NUM_DIGITS`: active-low one-hot digit enable (registered).
- `tick` output 1: one-cycle pulse on the last cycle of each slot.
- `frame` output 1: one-cycle pulse on the last cycle of slot `NUM_DIGITS-1`.

## Operation
- **Divider:** `div_cnt` counts `0 … DIV-1` and wraps to 0.
  - `tick` is 1 exactly when `div_cnt == DIV-1`.
  - `frame` equals `tick && sel == NUM_DIGITS-1`.
- **Slot index:** on the edge where `tick` is 1, `sel` advances by 1. It wraps from `NUM_DIGITS-1` to 0. The wrap is explicit compare, not modulo 2^n.
- **Outputs:** registered from the current `sel` and the data source each cycle.
  - `anode` = all ones, with bit `sel` cleared if `digit_en[sel]` is 1. Otherwise `anode` is all ones.
  - `selected_num` = `data[sel]` if `digit_en[sel]` is 1, else 0.
- **Blanked digits:** a blanked digit still consumes its full slot. Scan timing is independent of `digit_en`.
- **Data source:** live `num`, or the snapshot register (see Configuration).
- **Reset values:** `div_cnt`=0, `sel`=0, `anode`=all ones, `selected_num`=0, `tick`=0, `frame`=0, snapshot valid flag=0.
- **Reset mid-scan:** the reset values above are applied on the next edge. Scanning restarts at slot 0 with a full `DIV`-cycle slot.
- **Simultaneous `tick` and an input change:** the new `sel` is used on the following cycle. There is no priority conflict.

## Timing
- `anode` and `selected_num` lag `sel` by exactly 1 cycle.
  - Consequence: each digit is shown for `DIV` cycles, phase-shifted by 1 from `sel`.
- First edge after reset release:
  - `sel`=0, `div_cnt`=1.
  - `anode`/`selected_num` reflect digit 0 from that edge onward.
- Slot length is always `DIV` cycles. Frame length is `NUM_DIGITS*DIV` cycles.
- `tick` and `frame` are combinational decodes of registered state. They are glitch-free at clock edges and have no output register.
- A change on `num` or `digit_en` (live mode) appears on `selected_num`/`anode` 1 cycle later.

## Configuration
- **Macro:** `SEG_SCAN_SNAPSHOT_EN`.
- **Defined:** an internal `NUM_DIGITS*DIGIT_W` snapshot register holds the display data.
  - It loads `num` on any edge where the valid flag is 0 (the first cycle after reset), and on every edge where `frame` is 1.
  - The valid flag sets on the first load.
  - Digits then display the snapshot, so a whole frame shows coherent data and there is no tearing.
  - `digit_en` stays live, not snapshotted.
- **Undefined:** no snapshot register. `selected_num` uses live `num`.

## Test plan
- **Reset, then scan** (`NUM_DIGITS`=4, `DIV`=4, `num`={3,2,1,0} for digits 3..0, all enabled):
  - Hold `rst` 3 cycles: `anode`=4'b1111, `selected_num`=0, `sel`=0.
  - After release: `anode` goes 1110→1101→1011→0111, each for 4 cycles, with `selected_num` 0,1,2,3.
  - Then it wraps to 1110.
- **Non-power-of-two wrap** (`NUM_DIGITS`=3, `DIV`=2):
  - `sel` sequence is 0,0,1,1,2,2,0.
  - `sel` never reaches 3.
  - `frame` pulses every 6 cycles, on the cycle `sel`=2 and `tick`=1.
- **Blanking:**
  - `digit_en`=4'b1011: during slot 2, `anode`=4'b1111 and `selected_num`=0 for all `DIV` cycles.
  - The other slots are unaffected and the slot timing is unchanged.
- **Reset mid-slot:**
  - Assert `rst` for 1 cycle while `sel`=2 and `div_cnt`=1.
  - Next edge: `sel`=0, `div_cnt`=0, `anode`=all ones.
  - Digit 0 then shows for a full `DIV` cycles.
- **Snapshot** (macro defined, `NUM_DIGITS`=4, `DIV`=4):
  - Change `num[3]` from 3 to 9 during slot 1.
  - Slot 3 of the current frame still shows 3. The next frame shows 9.
  - With the macro undefined, 9 shows in the current frame.
- **`tick` cadence:** `DIV`=5 over 40 cycles gives exactly 8 `tick` pulses, each 1 cycle wide, spaced 5 cycles apart.

Source files
------------

// File: rtl/seg_scan_mux_if.sv
// Digit-scan bus between the digit-producing datapath (master) and the scanner (slave).
interface seg_scan_mux_if #(
    parameter int NUM_DIGITS = 8,
    parameter int DIGIT_W    = 4
);
    localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] num;
    logic [NUM_DIGITS-1:0]              digit_en;
    logic [SEL_W-1:0]                   sel;
    logic [DIGIT_W-1:0]                 selected_num;
    logic [NUM_DIGITS-1:0]              anode;
    logic                               tick;
    logic                               frame;

    modport master (
        output num, digit_en,
        input  sel, selected_num, anode, tick, frame
    );

    modport slave (
        input  num, digit_en,
        output sel, selected_num, anode, tick, frame
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed display scanner: one digit per DIV-cycle slot, active-low one-hot anodes.
// Optional frame-coherent snapshot of the digit values: define SEG_SCAN_SNAPSHOT_EN.
module seg_scan_mux #(
    parameter int NUM_DIGITS = 8,
    parameter int DIGIT_W    = 4,
    parameter int DIV        = 100000
) (
    input logic           clk,
    input logic           rst,
    seg_scan_mux_if.slave bus
);
    localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);

    typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

    logic [CNT_W-1:0]      div_cnt;
    logic [SEL_W-1:0]      sel_p0;
    logic [NUM_DIGITS-1:0] anode_p1;
    logic [DIGIT_W-1:0]    selected_num_p1;
    logic                  tick_w;
    logic                  frame_w;
    digits_t               data;

    // Explicit compare so non-power-of-two digit counts wrap correctly.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] s);
        next_sel = (s == SEL_LAST) ? '0 : s + SEL_W'(1);
    endfunction

    function automatic logic [NUM_DIGITS-1:0] anode_of(
        input logic [SEL_W-1:0]      s,
        input logic [NUM_DIGITS-1:0] en
    );
        anode_of = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (s == SEL_W'(i) && en[i]) anode_of[i] = 1'b0;
        end
    endfunction

    function automatic logic [DIGIT_W-1:0] digit_of(
        input logic [SEL_W-1:0]      s,
        input logic [NUM_DIGITS-1:0] en,
        input digits_t               d
    );
        digit_of = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (s == SEL_W'(i) && en[i]) digit_of = d[i];
        end
    endfunction

    assign tick_w  = (div_cnt == CNT_LAST);
    assign frame_w = tick_w && (sel_p0 == SEL_LAST);

`ifdef SEG_SCAN_SNAPSHOT_EN
    digits_t snap_p0;
    logic    snap_vld_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_vld_p0 <= 1'b0;
        end else if (!snap_vld_p0) begin
            snap_vld_p0 <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!snap_vld_p0 || frame_w) snap_p0 <= bus.num;
    end

    // Before the first load lands, show live data so digit 0 is right on the first edge.
    assign data = snap_vld_p0 ? snap_p0 : bus.num;
`else
    assign data = bus.num;
`endif

    // Stage 0: slot divider and slot index
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            sel_p0  <= '0;
        end else begin
            div_cnt <= tick_w ? '0 : div_cnt + CNT_W'(1);
            if (tick_w) sel_p0 <= next_sel(sel_p0);
        end
    end

    // Stage 1: digit select and anode decode, one cycle behind sel
    always_ff @(posedge clk) begin
        if (rst) begin
            anode_p1        <= '1;
            selected_num_p1 <= '0;
        end else begin
            anode_p1        <= anode_of(sel_p0, bus.digit_en);
            selected_num_p1 <= digit_of(sel_p0, bus.digit_en, data);
        end
    end

    assign bus.sel          = sel_p0;
    assign bus.anode        = anode_p1;
    assign bus.selected_num = selected_num_p1;
    assign bus.tick         = tick_w;
    assign bus.frame        = frame_w;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: scan order, wrap, blanking, snapshot, mid-slot reset, tick cadence.
module tb_seg_scan_mux;
    logic clk;
    logic rst4, rst3, rst5;
    int   total = 0;
    int   bad   = 0;

    seg_scan_mux_if #(.NUM_DIGITS(4), .DIGIT_W(4)) bus4 ();
    seg_scan_mux_if #(.NUM_DIGITS(3), .DIGIT_W(4)) bus3 ();
    seg_scan_mux_if #(.NUM_DIGITS(4), .DIGIT_W(4)) bus5 ();

    seg_scan_mux #(.NUM_DIGITS(4), .DIGIT_W(4), .DIV(4)) u4 (.clk(clk), .rst(rst4), .bus(bus4));
    seg_scan_mux #(.NUM_DIGITS(3), .DIGIT_W(4), .DIV(2)) u3 (.clk(clk), .rst(rst3), .bus(bus3));
    seg_scan_mux #(.NUM_DIGITS(4), .DIGIT_W(4), .DIV(5)) u5 (.clk(clk), .rst(rst5), .bus(bus5));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         digit;
        int         ev;
        int         n5;
        int         last5;
        int         first5;
        logic [3:0] en;
        logic [3:0] ea;

        rst4 = 1'b1;
        rst3 = 1'b1;
        rst5 = 1'b1;
        bus4.num      = {4'd3, 4'd2, 4'd1, 4'd0};
        bus4.digit_en = 4'b1111;
        bus3.num      = {4'd2, 4'd1, 4'd0};
        bus3.digit_en = 3'b111;
        bus5.num      = {4'd7, 4'd6, 4'd5, 4'd4};
        bus5.digit_en = 4'b1111;

        // three reset cycles
        for (int r = 0; r < 3; r++) begin
            step();
            chk($sformatf("rst_anode r=%0d", r), 32'(bus4.anode), 32'hF);
            chk($sformatf("rst_num r=%0d", r), 32'(bus4.selected_num), 32'h0);
            chk($sformatf("rst_sel r=%0d", r), 32'(bus4.sel), 32'h0);
        end
        chk("rst_tick", 32'(bus4.tick), 32'h0);
        chk("rst_frame3", 32'(bus3.frame), 32'h0);
        chk("rst_anode3", 32'(bus3.anode), 32'h7);
        rst4 = 1'b0;
        rst3 = 1'b0;
        rst5 = 1'b0;

        step();
        chk("first_divcnt", 32'(u4.div_cnt), 32'd1);

        n5 = 0;
        last5 = -1;
        first5 = -1;
        // k indexes samples taken after edge k+1 following reset release
        for (int k = 0; k < 64; k++) begin
            if (k > 0) step();
            digit = (k / 4) % 4;
            en = (k >= 17 && k <= 32) ? 4'b1011 : 4'b1111;
            ea = 4'hF;
            if (en[digit]) ea[digit] = 1'b0;
            ev = digit;
`ifdef SEG_SCAN_SNAPSHOT_EN
            if (digit == 3 && k >= 48) ev = 9;
`else
            if (digit == 3 && k >= 44) ev = 9;
`endif
            if (!en[digit]) ev = 0;

            chk($sformatf("anode4 k=%0d", k), 32'(bus4.anode), 32'(ea));
            chk($sformatf("num4 k=%0d", k), 32'(bus4.selected_num), 32'(ev));
            chk($sformatf("sel4 k=%0d", k), 32'(bus4.sel), 32'(((k + 1) / 4) % 4));
            chk($sformatf("tick4 k=%0d", k), 32'(bus4.tick), 32'(k % 4 == 2));
            chk($sformatf("frame4 k=%0d", k), 32'(bus4.frame), 32'(k % 16 == 14));

            if (k < 18) begin
                chk($sformatf("sel3 k=%0d", k), 32'(bus3.sel), 32'(((k + 1) / 2) % 3));
                chk($sformatf("tick3 k=%0d", k), 32'(bus3.tick), 32'(k % 2 == 0));
                chk($sformatf("frame3 k=%0d", k), 32'(bus3.frame), 32'(k % 6 == 4));
            end

            if (k < 40 && bus5.tick) begin
                n5++;
                if (last5 >= 0) chk($sformatf("tick5_gap k=%0d", k), 32'(k - last5), 32'd5);
                else first5 = k;
                last5 = k;
            end

            if (k == 16) bus4.digit_en = 4'b1011;
            if (k == 32) bus4.digit_en = 4'b1111;
            if (k == 37) bus4.num[3] = 4'd9;
        end
        chk("tick5_count", 32'(n5), 32'd8);
        chk("tick5_first", 32'(first5), 32'd3);

        // run to sel=2, div_cnt=1, then pulse reset for one cycle
        for (int i = 0; i < 9; i++) step();
        chk("pre_rst_sel", 32'(bus4.sel), 32'd2);
        chk("pre_rst_div", 32'(u4.div_cnt), 32'd1);
        rst4 = 1'b1;
        step();
        chk("mid_rst_sel", 32'(bus4.sel), 32'd0);
        chk("mid_rst_div", 32'(u4.div_cnt), 32'd0);
        chk("mid_rst_anode", 32'(bus4.anode), 32'hF);
        chk("mid_rst_num", 32'(bus4.selected_num), 32'h0);
        rst4 = 1'b0;
        for (int j = 0; j < 5; j++) begin
            step();
            chk($sformatf("post_rst_anode j=%0d", j), 32'(bus4.anode), (j < 4) ? 32'hE : 32'hD);
            chk($sformatf("post_rst_num j=%0d", j), 32'(bus4.selected_num), (j < 4) ? 32'd0 : 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
